// File: rtl/conv2_engine.sv
// Raster-order 2-D valid convolution with a fixed checkerboard kernel, one output pixel per clock.
// Define CONV2_SATURATE_EN to clamp oversized sums to the pixel maximum instead of wrapping.
module conv2_engine #(
  parameter int SIZE      = 5,
  parameter int SIZEKer   = 3,
  parameter int WIDTH_BIT = 8,
  localparam int OUT      = SIZE - SIZEKer + 1
) (
  input  logic                 clock,
  input  logic                 nreset,
  input  logic [WIDTH_BIT-1:0] inpMatrixI      [SIZE][SIZE],
  output logic                 done,
  output logic [WIDTH_BIT-1:0] convIxKernelOut [OUT][OUT]
);

  localparam int IW     = (OUT > 1) ? $clog2(OUT) : 1;
  localparam int AW     = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int SUMW   = WIDTH_BIT + $clog2(SIZEKer * SIZEKer);
  localparam int MAXPIX = (1 << WIDTH_BIT) - 1;

  typedef enum logic {RUN, DONE} state_t;

  state_t               state, stateNxt;
  logic [IW-1:0]        rowIdx, colIdx, rowNxt, colNxt;
  logic                 wrEn;
  logic [SUMW-1:0]      winSum;
  logic [WIDTH_BIT-1:0] pixOut;

  // Window sum at the current (row, col); only even-parity kernel taps contribute.
  always_comb begin
    winSum = '0;
    for (int r = 0; r < SIZEKer; r++)
      for (int c = 0; c < SIZEKer; c++)
        if (((r + c) % 2) == 0)
          winSum = winSum + SUMW'(inpMatrixI[AW'(32'(rowIdx) + r)][AW'(32'(colIdx) + c)]);
  end

  always_comb begin
`ifdef CONV2_SATURATE_EN
    pixOut = (winSum > SUMW'(MAXPIX)) ? '1 : winSum[WIDTH_BIT-1:0];
`else
    pixOut = winSum[WIDTH_BIT-1:0];
`endif
  end

  always_comb begin
    stateNxt = state;
    rowNxt   = rowIdx;
    colNxt   = colIdx;
    wrEn     = 1'b0;
    case (state)
      RUN: begin
        wrEn = 1'b1;
        if (colIdx < IW'(OUT - 1)) begin
          colNxt = colIdx + 1'b1;
        end else if (rowIdx < IW'(OUT - 1)) begin
          colNxt = '0;
          rowNxt = rowIdx + 1'b1;
        end else begin
          stateNxt = DONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) begin
      state  <= RUN;
      rowIdx <= '0;
      colIdx <= '0;
    end else begin
      state  <= stateNxt;
      rowIdx <= rowNxt;
      colIdx <= colNxt;
    end
  end

  // Only the addressed pixel register loads; all others hold.
  always_ff @(posedge clock or posedge nreset) begin
    if (nreset) begin
      for (int i = 0; i < OUT; i++)
        for (int j = 0; j < OUT; j++)
          convIxKernelOut[i][j] <= '0;
    end else begin
      for (int i = 0; i < OUT; i++)
        for (int j = 0; j < OUT; j++)
          if (wrEn && rowIdx == IW'(i) && colIdx == IW'(j))
            convIxKernelOut[i][j] <= pixOut;
    end
  end

  assign done = (state == DONE);

endmodule

// File: tb/tb_conv2_engine.sv
// Scoreboard bench for conv2_engine: stimulus queues expected values, a negedge monitor compares them.
module tb_conv2_engine;

  logic       clock = 1'b0;
  logic       nreset = 1'b1;
  logic [7:0] img  [5][5];
  logic       done;
  logic [7:0] outImg [3][3];

  typedef struct {
    string       name;
    bit          isDone;
    int          i;
    int          j;
    logic [31:0] val;
  } exp_t;

  exp_t sbQ[$];
  int   checks = 0;
  int   errors = 0;

`ifdef CONV2_SATURATE_EN
  localparam int EXP_FF = 8'hFF;
`else
  localparam int EXP_FF = 8'hFB;
`endif

  conv2_engine #(.SIZE(5), .SIZEKer(3), .WIDTH_BIT(8)) dut (
    .clock           (clock),
    .nreset          (nreset),
    .inpMatrixI      (img),
    .done            (done),
    .convIxKernelOut (outImg)
  );

  always #5 clock = ~clock;

  // Monitor: drains every pending expectation away from the active edge.
  always @(negedge clock) begin
    while (sbQ.size() > 0) begin
      exp_t        e;
      logic [31:0] act;
      e   = sbQ.pop_front();
      act = e.isDone ? {31'd0, done} : {24'd0, outImg[e.i][e.j]};
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s [%0d][%0d]: got %0d, expected %0d", e.name, e.i, e.j, act, e.val);
      end
    end
  end

  task automatic pushPix(input string nm, input int i, input int j, input int v);
    exp_t e;
    e.name = nm; e.isDone = 1'b0; e.i = i; e.j = j; e.val = v;
    sbQ.push_back(e);
  endtask

  task automatic pushDone(input string nm, input bit v);
    exp_t e;
    e.name = nm; e.isDone = 1'b1; e.i = 0; e.j = 0; e.val = {31'd0, v};
    sbQ.push_back(e);
  endtask

  // ramp=1: hand-derived 25i+5j+30 for the 5r+c image; otherwise constant cval.
  task automatic pushImg(input string nm, input bit ramp, input int cval);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        pushPix(nm, i, j, ramp ? (25 * i + 5 * j + 30) : cval);
  endtask

  task automatic setAll(input logic [7:0] v);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[r][c] = v;
  endtask

  task automatic setRamp();
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        img[r][c] = 8'(5 * r + c);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Hold reset for one edge, then release just after an edge so the next edge is edge 1.
  task automatic doReset();
    nreset = 1'b1;
    step(1);
    nreset = 1'b0;
  endtask

  initial begin
    setAll(8'h01);
    step(1);

    // Test 1: reset state, then all-ones image; done rises exactly on edge 9.
    pushDone("rst_done", 1'b0);
    pushImg("rst_pix", 1'b0, 0);
    doReset();
    for (int k = 1; k <= 9; k++) begin
      step(1);
      pushDone("t1_done", k == 9);
    end
    pushImg("t1_ones", 1'b0, 5);
    step(1);

    // Test 2 + 6: ramp image, raster-order snapshot after edge 4.
    setRamp();
    doReset();
    step(4);
    pushPix("t6_r0", 0, 0, 30);
    pushPix("t6_r0", 0, 1, 35);
    pushPix("t6_r0", 0, 2, 40);
    pushPix("t6_r1", 1, 0, 55);
    pushPix("t6_zero", 1, 1, 0);
    pushPix("t6_zero", 1, 2, 0);
    for (int j = 0; j < 3; j++) pushPix("t6_zero", 2, j, 0);
    pushDone("t6_done", 1'b0);
    step(5);
    pushImg("t2_ramp", 1'b1, 0);
    pushDone("t2_done", 1'b1);
    step(1);

    // Test 3: all 0xFF, wrap or saturate depending on the build.
    setAll(8'hFF);
    doReset();
    step(8);
    pushDone("t3_done8", 1'b0);
    step(1);
    pushImg("t3_ff", 1'b0, EXP_FF);
    pushDone("t3_done", 1'b1);
    step(1);

    // Test 4: reset mid-run clears immediately, then a clean rerun.
    setRamp();
    doReset();
    step(4);
    nreset = 1'b1;
    #1;
    pushImg("t4_clear", 1'b0, 0);
    pushDone("t4_clr_done", 1'b0);
    step(1);
    nreset = 1'b0;
    step(8);
    pushDone("t4_done8", 1'b0);
    step(1);
    pushImg("t4_rerun", 1'b1, 0);
    pushDone("t4_done", 1'b1);
    step(1);

    // Test 5: once done, input changes and extra edges leave everything alone.
    setAll(8'h01);
    step(20);
    pushImg("t5_hold", 1'b1, 0);
    pushDone("t5_done", 1'b1);

    // Bounded drain of the scoreboard.
    for (int k = 0; k < 10 && sbQ.size() > 0; k++) @(negedge clock);
    #1;
    if (sbQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sbQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
